// File: rtl/arb_pkg.sv
// Shared types and helpers for the multi-port cache arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   localparam int LINE_OFFSET_BITS = 6;
   localparam int MAX_ADDR_W       = 128;

   // Clears the byte offset inside a cache line; callers resize to and from MAX_ADDR_W.
   function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr);
      return {addr[MAX_ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker: the search starts one past the last granted port.
module rr_picker #(
   parameter int NPORTS = 2,
   parameter int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
   input  logic [NPORTS-1:0] req_i,
   input  logic [IDX_W-1:0]  last_i,
   output logic [NPORTS-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o
);

   always_comb begin
      logic found;
      int   p;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      p       = 0;
      for (int i = 1; i <= NPORTS; i++) begin
         p = (int'(last_i) + i) % NPORTS;
         if (!found && req_i[p]) begin
            found      = 1'b1;
            grant_o[p] = 1'b1;
            idx_o      = IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/multi_port_arbiter.sv
// Round-robin arbiter sharing one memory controller among NPORTS cache requesters,
// with write-invalidate broadcast and external snoop forwarding.
module multi_port_arbiter
   import arb_pkg::*;
#(
   parameter int                NPORTS     = 2,
   parameter int                ADDR_W     = 64,
   parameter int                LINE_W     = 512,
   parameter logic [NPORTS-1:0] SNOOP_MASK = {NPORTS{1'b1}}
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NPORTS-1:0]        req_valid,
   input  logic [NPORTS-1:0]        req_wr,
   input  logic [NPORTS*ADDR_W-1:0] req_addr,
   input  logic [NPORTS*LINE_W-1:0] req_data,
   output logic [NPORTS-1:0]        resp_done,
   output logic [LINE_W-1:0]        resp_data,
   output logic                     mem_req,
   output logic                     mem_wr_en,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [LINE_W-1:0]        mem_data_out,
   input  logic                     mem_data_valid,
   input  logic [LINE_W-1:0]        mem_data_in,
   input  logic                     inv_in,
   input  logic [ADDR_W-1:0]        inv_addr_in,
   output logic [NPORTS-1:0]        inv_out,
   output logic [ADDR_W-1:0]        inv_addr_out
);

   localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  last_q, gidx_q, pick_idx;
   logic [NPORTS-1:0] pick_grant, gnt_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [NPORTS-1:0] resp_done_q;
   logic [LINE_W-1:0] resp_data_q;
   logic [NPORTS-1:0] inv_out_q, pend_mask_q, wr_inv_mask;
   logic [ADDR_W-1:0] inv_addr_q, pend_addr_q, wr_inv_addr;
   logic              pend_q;
   logic              accept, complete, wr_inv;

   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
      return ADDR_W'(line_align(MAX_ADDR_W'(a)));
   endfunction

   rr_picker #(
      .NPORTS (NPORTS),
      .IDX_W  (IDX_W)
   ) u_picker (
      .req_i   (req_valid),
      .last_i  (last_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   assign accept      = (state_q == IDLE) && (state_d == BUSY);
   assign complete    = (state_q == BUSY) && mem_data_valid;
   assign wr_inv      = complete && wr_q;
   assign wr_inv_mask = SNOOP_MASK & ~gnt_q;
   assign wr_inv_addr = align_addr(addr_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A held-back invalidate must drain before a new transaction may start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid && !pend_q) state_d = BUSY;
         BUSY:    if (mem_data_valid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_wr_en = 1'b0;
      if (state_q == BUSY) begin
         mem_req   = 1'b1;
         mem_wr_en = wr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gidx_q      <= '0;
         gnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_q      <= IDX_W'(NPORTS - 1);
         resp_done_q <= '0;
         resp_data_q <= '0;
      end else begin
         resp_done_q <= '0;
         if (accept) begin
            gidx_q  <= pick_idx;
            gnt_q   <= pick_grant;
            wr_q    <= req_wr[pick_idx];
            addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            wdata_q <= req_data[pick_idx*LINE_W +: LINE_W];
         end
         if (complete) begin
            resp_done_q <= gnt_q;
            resp_data_q <= wr_q ? '0 : mem_data_in;
            last_q      <= gidx_q;
         end
      end
   end

   // External snoops take the output slot; a colliding write invalidate waits one entry deep.
   always_ff @(posedge clk) begin
      if (reset) begin
         inv_out_q   <= '0;
         inv_addr_q  <= '0;
         pend_q      <= 1'b0;
         pend_mask_q <= '0;
         pend_addr_q <= '0;
      end else begin
         inv_out_q <= '0;
         if (inv_in) begin
            inv_out_q  <= SNOOP_MASK;
            inv_addr_q <= align_addr(inv_addr_in);
            if (wr_inv) begin
               pend_q      <= 1'b1;
               pend_mask_q <= wr_inv_mask;
               pend_addr_q <= wr_inv_addr;
            end
         end else if (pend_q) begin
            inv_out_q  <= pend_mask_q;
            inv_addr_q <= pend_addr_q;
            pend_q     <= 1'b0;
         end else if (wr_inv) begin
            inv_out_q  <= wr_inv_mask;
            inv_addr_q <= wr_inv_addr;
         end
      end
   end

   assign resp_done    = resp_done_q;
   assign resp_data    = resp_data_q;
   assign mem_addr     = addr_q;
   assign mem_data_out = wdata_q;
   assign inv_out      = inv_out_q;
   assign inv_addr_out = inv_addr_q;

endmodule

// File: tb/tb_multi_port_arbiter.sv
// Scoreboard bench for multi_port_arbiter: a 2-port instance and a 4-port instance.
module tb_multi_port_arbiter;

   localparam int AW = 64, LW = 512, AW4 = 32, LW4 = 64, LAT4 = 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 2-port instance
   logic [1:0]      req_valid, req_wr, resp_done, inv_out;
   logic [2*AW-1:0] req_addr;
   logic [2*LW-1:0] req_data;
   logic [LW-1:0]   resp_data, mem_data_out, mem_data_in;
   logic [AW-1:0]   mem_addr, inv_addr_in, inv_addr_out;
   logic            mem_req, mem_wr_en, mem_data_valid, inv_in;

   // 4-port instance
   logic [3:0]       req_valid4, req_wr4, resp_done4, inv_out4;
   logic [4*AW4-1:0] req_addr4;
   logic [4*LW4-1:0] req_data4;
   logic [LW4-1:0]   resp_data4, mem_data_out4, mem_data_in4;
   logic [AW4-1:0]   mem_addr4, inv_addr_in4, inv_addr_out4;
   logic             mem_req4, mem_wr_en4, mem_data_valid4, inv_in4;

   multi_port_arbiter #(.NPORTS(2), .ADDR_W(AW), .LINE_W(LW)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data), .resp_done(resp_done),
      .resp_data(resp_data), .mem_req(mem_req), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .mem_data_in(mem_data_in), .inv_in(inv_in), .inv_addr_in(inv_addr_in),
      .inv_out(inv_out), .inv_addr_out(inv_addr_out));

   multi_port_arbiter #(.NPORTS(4), .ADDR_W(AW4), .LINE_W(LW4)) u_dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid4), .req_wr(req_wr4),
      .req_addr(req_addr4), .req_data(req_data4), .resp_done(resp_done4),
      .resp_data(resp_data4), .mem_req(mem_req4), .mem_wr_en(mem_wr_en4),
      .mem_addr(mem_addr4), .mem_data_out(mem_data_out4), .mem_data_valid(mem_data_valid4),
      .mem_data_in(mem_data_in4), .inv_in(inv_in4), .inv_addr_in(inv_addr_in4),
      .inv_out(inv_out4), .inv_addr_out(inv_addr_out4));

   typedef struct { int port; logic [LW-1:0] data; } resp_t;
   typedef struct { logic [1:0] mask; logic [AW-1:0] addr; } inv_t;

   resp_t resp_q[$];
   inv_t  inv_q[$];
   int    grant_q[$];

   task automatic wait_mem_req(input bit four, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((four ? mem_req4 : mem_req) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr_en: got %b want 0", mem_wr_en); end
      n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      n_tests++; if (mem_data_out !== '0) begin n_fail++; $display("FAIL rst_mem_data_out: got %h want 0", mem_data_out); end
      n_tests++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL rst_resp_done: got %b want 00", resp_done); end
      n_tests++; if (resp_data !== '0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
      n_tests++; if (inv_out !== 2'b00) begin n_fail++; $display("FAIL rst_inv_out: got %b want 00", inv_out); end
      n_tests++; if (inv_addr_out !== '0) begin n_fail++; $display("FAIL rst_inv_addr_out: got %h want 0", inv_addr_out); end
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if ({mem_req4, resp_done4, inv_out4} !== 9'd0) begin
         n_fail++; $display("FAIL rst_dut4: got %b want 0", {mem_req4, resp_done4, inv_out4});
      end
   endtask

   task automatic test_single_read();
      bit ok;
      int n_req;
      resp_t er;
      er.port = 0;
      er.data = {8{64'hA5A5_A5A5_A5A5_A5A5}};
      resp_q.push_back(er);
      req_addr[0 +: AW] = 64'h1000;
      req_wr    = 2'b00;
      req_valid = 2'b01;
      wait_mem_req(1'b0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL read_start: mem_req never rose within 20 cycles"); end
      n_tests++; if (mem_addr !== 64'h1000 || mem_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL read_addr: got %h/%b want 1000/0", mem_addr, mem_wr_en);
      end
      n_req = 1;
      repeat (2) begin
         @(negedge clk);
         if (mem_req === 1'b1) n_req++;
      end
      mem_data_valid = 1'b1;
      mem_data_in    = {8{64'hA5A5_A5A5_A5A5_A5A5}};
      @(negedge clk);
      mem_data_valid = 1'b0;
      mem_data_in    = '1;
      req_valid      = 2'b00;
      er = resp_q.pop_front();
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL read_req_drop: got %b want 0", mem_req); end
      n_tests++; if (resp_done !== 2'(1 << er.port)) begin
         n_fail++; $display("FAIL read_resp_done: got %b want %b", resp_done, 2'(1 << er.port));
      end
      n_tests++; if (resp_data !== er.data) begin n_fail++; $display("FAIL read_resp_data: got %h want %h", resp_data, er.data); end
      @(negedge clk);
      n_tests++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL read_resp_once: got %b want 00", resp_done); end
      n_tests++; if (n_req !== 3) begin n_fail++; $display("FAIL read_req_cycles: got %0d want 3", n_req); end
   endtask

   task automatic test_fairness();
      bit ok;
      int g, rise, prev_rise;
      logic [LW4-1:0] d;
      for (int k = 0; k < 5; k++) grant_q.push_back(k % 4);
      for (int p = 0; p < 4; p++) req_addr4[p*AW4 +: AW4] = AW4'(32'h100 * (p + 1));
      req_wr4    = 4'b0000;
      req_valid4 = 4'b1111;
      prev_rise  = 0;
      for (int k = 0; k < 5; k++) begin
         wait_mem_req(1'b1, ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_start%0d: mem_req never rose", k); end
         rise = cyc;
         g    = grant_q.pop_front();
         d    = 64'hF00D_0000_0000_0000 | 64'(g);
         n_tests++; if (mem_addr4 !== AW4'(32'h100 * (g + 1))) begin
            n_fail++; $display("FAIL rr_grant%0d: got addr %h want %h", k, mem_addr4, AW4'(32'h100 * (g + 1)));
         end
         if (k > 0) begin
            n_tests++; if (rise - prev_rise !== LAT4 + 2) begin
               n_fail++; $display("FAIL rr_period%0d: got %0d want %0d", k, rise - prev_rise, LAT4 + 2);
            end
         end
         prev_rise = rise;
         repeat (LAT4 - 1) @(negedge clk);
         mem_data_valid4 = 1'b1;
         mem_data_in4    = d;
         @(negedge clk);
         mem_data_valid4 = 1'b0;
         if (k == 4) req_valid4 = 4'b0000;
         n_tests++; if (resp_done4 !== 4'(1 << g) || resp_data4 !== d) begin
            n_fail++; $display("FAIL rr_resp%0d: got %b/%h want %b/%h", k, resp_done4, resp_data4, 4'(1 << g), d);
         end
      end
   endtask

   task automatic test_write_inv();
      bit ok;
      resp_t er;
      inv_t ei;
      er.port = 1; er.data = '0; resp_q.push_back(er);
      ei.mask = 2'b01; ei.addr = 64'h2040; inv_q.push_back(ei);
      req_addr[AW +: AW] = 64'h2047;
      req_data[LW +: LW] = {16{32'hC0DE_0001}};
      req_wr    = 2'b10;
      req_valid = 2'b10;
      wait_mem_req(1'b0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL wr_start: mem_req never rose"); end
      n_tests++; if (mem_wr_en !== 1'b1 || mem_addr !== 64'h2047 || mem_data_out !== {16{32'hC0DE_0001}}) begin
         n_fail++; $display("FAIL wr_mem: got %b/%h want 1/2047", mem_wr_en, mem_addr);
      end
      mem_data_valid = 1'b1;
      mem_data_in    = '1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      req_valid = 2'b00;
      req_wr    = 2'b00;
      er = resp_q.pop_front();
      ei = inv_q.pop_front();
      n_tests++; if (resp_done !== 2'(1 << er.port) || resp_data !== er.data) begin
         n_fail++; $display("FAIL wr_resp: got %b/%h want %b/0", resp_done, resp_data, 2'(1 << er.port));
      end
      n_tests++; if (inv_out !== ei.mask || inv_addr_out !== ei.addr) begin
         n_fail++; $display("FAIL wr_inv: got %b/%h want %b/%h", inv_out, inv_addr_out, ei.mask, ei.addr);
      end
      @(negedge clk);
      n_tests++; if (inv_out !== 2'b00) begin n_fail++; $display("FAIL wr_inv_pulse: got %b want 00", inv_out); end
   endtask

   task automatic test_collision();
      bit ok;
      inv_t ei;
      ei.mask = 2'b11; ei.addr = 64'h3000; inv_q.push_back(ei);
      ei.mask = 2'b11; ei.addr = 64'h3080; inv_q.push_back(ei);
      ei.mask = 2'b10; ei.addr = 64'h4000; inv_q.push_back(ei);
      req_addr[0 +: AW]  = 64'h4000;
      req_addr[AW +: AW] = 64'h5000;
      req_wr    = 2'b01;
      req_valid = 2'b01;
      wait_mem_req(1'b0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL col_start: mem_req never rose"); end
      mem_data_valid = 1'b1;
      inv_in         = 1'b1;
      inv_addr_in    = 64'h3000;
      @(negedge clk);
      mem_data_valid = 1'b0;
      inv_addr_in    = 64'h3085;
      req_wr    = 2'b00;
      req_valid = 2'b10;
      ei = inv_q.pop_front();
      n_tests++; if (resp_done !== 2'b01) begin n_fail++; $display("FAIL col_resp: got %b want 01", resp_done); end
      n_tests++; if (inv_out !== ei.mask || inv_addr_out !== ei.addr) begin
         n_fail++; $display("FAIL col_snoop1: got %b/%h want %b/%h", inv_out, inv_addr_out, ei.mask, ei.addr);
      end
      @(negedge clk);
      inv_in = 1'b0;
      ei = inv_q.pop_front();
      n_tests++; if (inv_out !== ei.mask || inv_addr_out !== ei.addr) begin
         n_fail++; $display("FAIL col_snoop2: got %b/%h want %b/%h", inv_out, inv_addr_out, ei.mask, ei.addr);
      end
      @(negedge clk);
      ei = inv_q.pop_front();
      n_tests++; if (inv_out !== ei.mask || inv_addr_out !== ei.addr) begin
         n_fail++; $display("FAIL col_pending: got %b/%h want %b/%h", inv_out, inv_addr_out, ei.mask, ei.addr);
      end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL col_blocked: got mem_req %b want 0", mem_req); end
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_addr !== 64'h5000) begin
         n_fail++; $display("FAIL col_next: got %b/%h want 1/5000", mem_req, mem_addr);
      end
      mem_data_valid = 1'b1;
      mem_data_in    = {8{64'h0123_4567_89AB_CDEF}};
      @(negedge clk);
      mem_data_valid = 1'b0;
      req_valid      = 2'b00;
      n_tests++; if (resp_done !== 2'b10 || resp_data !== {8{64'h0123_4567_89AB_CDEF}}) begin
         n_fail++; $display("FAIL col_next_resp: got %b/%h want 10", resp_done, resp_data);
      end
   endtask

   task automatic test_reset_mid_busy();
      bit ok;
      req_addr[0 +: AW] = 64'h6000;
      req_valid = 2'b01;
      wait_mem_req(1'b0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rmb_start: mem_req never rose"); end
      reset     = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmb_drop: got %b want 0", mem_req); end
      mem_data_valid = 1'b1;
      mem_data_in    = '1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      n_tests++; if (resp_done !== 2'b00) begin n_fail++; $display("FAIL rmb_no_resp: got %b want 00", resp_done); end
      @(negedge clk);
      n_tests++; if (resp_done !== 2'b00 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL rmb_late_valid: got %b/%b want 00/0", resp_done, mem_req);
      end
   endtask

   task automatic test_abort();
      bit ok;
      resp_t er;
      er.port = 1; er.data = {16{32'hBEEF_0042}}; resp_q.push_back(er);
      req_addr[AW +: AW] = 64'h7000;
      req_valid = 2'b10;
      wait_mem_req(1'b0, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_start: mem_req never rose"); end
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_addr !== 64'h7000) begin
         n_fail++; $display("FAIL abort_hold: got %b/%h want 1/7000", mem_req, mem_addr);
      end
      mem_data_valid = 1'b1;
      mem_data_in    = {16{32'hBEEF_0042}};
      @(negedge clk);
      mem_data_valid = 1'b0;
      er = resp_q.pop_front();
      n_tests++; if (resp_done !== 2'(1 << er.port) || resp_data !== er.data) begin
         n_fail++; $display("FAIL abort_resp: got %b/%h want %b/%h", resp_done, resp_data, 2'(1 << er.port), er.data);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
      mem_data_valid = 1'b0; mem_data_in = '0; inv_in = 1'b0; inv_addr_in = '0;
      req_valid4 = '0; req_wr4 = '0; req_addr4 = '0; req_data4 = '0;
      mem_data_valid4 = 1'b0; mem_data_in4 = '0; inv_in4 = 1'b0; inv_addr_in4 = '0;
      test_reset();
      test_single_read();
      test_fairness();
      test_write_inv();
      test_collision();
      test_reset_mid_busy();
      test_abort();
      n_tests++; if (resp_q.size() != 0 || inv_q.size() != 0 || grant_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d/%0d entries left want 0", resp_q.size(), inv_q.size(), grant_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multi_port_arbiter.md
MULTI_PORT_ARBITER -- requirements
Module: multi_port_arbiter

Interface
REQ-001 Parameters SHALL be: NPORTS (default 2), number of cache requesters, legal range 2..8.
REQ-002 Parameters SHALL be: ADDR_W (default 64), byte address width.
REQ-003 Parameters SHALL be: LINE_W (default 512), cache-line width in bits.
REQ-004 Parameters SHALL be: SNOOP_MASK (default all ones, NPORTS bits), ports that receive invalidations.
REQ-005 Ports SHALL be as follows; port p's slice of a packed vector occupies bits [p*W +: W]. Reset is reset, synchronous, active-high; the clock is clk.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NPORTS  per-port request, level, held until resp_done
- req_wr  in  NPORTS  1 = line write, 0 = line read
- req_addr  in  NPORTS*ADDR_W  per-port line address
- req_data  in  NPORTS*LINE_W  per-port write data
- resp_done  out  NPORTS  one-cycle completion pulse to the granted port
- resp_data  out  LINE_W  read data, valid while resp_done is high
- mem_req  out  1  request to the memory controller, level
- mem_wr_en  out  1  write qualifier for mem_req
- mem_addr  out  ADDR_W  request address
- mem_data_out  out  LINE_W  write data
- mem_data_valid  in  1  controller completion pulse
- mem_data_in  in  LINE_W  controller read data
- inv_in  in  1  external snoop invalidate pulse
- inv_addr_in  in  ADDR_W  snoop address
- inv_out  out  NPORTS  per-port invalidate pulse
- inv_addr_out  out  ADDR_W  invalidate address, 64-byte aligned

Function
REQ-006 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-007 IDLE: when any req_valid is high at edge t, the block SHALL register grant g, addr, wr and data, and assert mem_req from cycle t+1 (state BUSY).
REQ-008 Grant SHALL be round-robin: search starts at (last_grant+1) mod NPORTS; the first requesting port wins.
REQ-009 BUSY: mem_req, mem_wr_en, mem_addr and mem_data_out SHALL hold stable until mem_data_valid is sampled high.
REQ-010 On mem_data_valid at edge u, mem_req SHALL drop at u+1 and the FSM SHALL enter DONE.
REQ-011 In the DONE cycle, resp_done[g] SHALL be 1, resp_data SHALL equal the captured mem_data_in (zero for writes), and last_grant SHALL update to g.
REQ-012 DONE SHALL go to IDLE unconditionally, so a back-to-back request sees mem_req at u+3.
REQ-013 A port deasserting req_valid during BUSY SHALL NOT abort the transaction; resp_done still pulses.
REQ-014 A mem_data_valid arriving while in IDLE or DONE SHALL be ignored.
REQ-015 Write coherence: on completion of a write by port g, inv_out[k] SHALL pulse in the DONE cycle for every k != g with SNOOP_MASK[k]=1, and inv_addr_out SHALL be addr with bits [5:0] cleared.
REQ-016 External snoop: inv_in at edge t SHALL pulse inv_out[k] for every k with SNOOP_MASK[k]=1 at cycle t+1, independent of FSM state.
REQ-017 Collision: if an external snoop and a write invalidate fall in the same cycle, the external snoop SHALL win, and the write invalidate SHALL be held in a 1-entry pending register and issued the next cycle.
REQ-018 A pending register that is full SHALL prevent the FSM from leaving IDLE.
REQ-019 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-020 On reset, the block SHALL force state IDLE, last_grant=NPORTS-1 (port 0 highest priority), and clear the pending register.
REQ-021 On reset, the following outputs SHALL be 0: mem_req, mem_wr_en, mem_addr, mem_data_out, resp_done, resp_data, inv_out, inv_addr_out.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction silently: mem_req drops at the next edge and no resp_done is issued.

Structure
REQ-023 The FSM state enum, LINE_OFFSET_BITS=6 and the invalidate-address alignment function SHALL reside in a shared package, arb_pkg.
REQ-024 The grant-selection logic SHALL be a sub-module, rr_picker, parametrised by NPORTS: inputs are the request vector and last_grant; outputs are the one-hot grant and its index.

Verification
REQ-025 Single read: NPORTS=2, port0 reads 0x1000, controller returns 0xA5.. after 3 cycles -> mem_req for exactly 3 cycles, resp_done[0] pulses once with resp_data=0xA5.., and resp_done[1]=0.
REQ-026 Fairness: NPORTS=4, all ports request continuously -> grant order 0,1,2,3,0; each transaction takes latency+2 cycles.
REQ-027 Write invalidate: port1 writes 0x2047 -> at resp_done[1], inv_out=0b01 and inv_addr_out=0x2040.
REQ-028 Collision: inv_in with addr 0x3000 in the same cycle a write from port0 to 0x4000 completes -> inv_out carries 0x3000 first, then 0x4000 the next cycle with inv_out[0]=0.
REQ-029 Reset mid-BUSY: reset pulses while mem_req=1 -> mem_req=0 next cycle; a late mem_data_valid produces no resp_done.
REQ-030 Abort attempt: req_valid drops during BUSY -> the transaction still completes and resp_done pulses.
